// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-master RAM port arbiter.
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips to the loser only on a contested grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_pri,
  input  logic       i_update,
  output logic [1:0] o_gnt,
  output logic       o_next_pri
);

  logic w_both;

  assign w_both = i_req[0] & i_req[1];

  always_comb begin
    o_gnt      = 2'b00;
    o_next_pri = i_pri;
    if (i_update) begin
      if (w_both) begin
        o_gnt      = (i_pri == M1) ? 2'b10 : 2'b01;
        o_next_pri = ~i_pri;
      end else begin
        o_gnt = i_req;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM between M0 and M1 with independent write and read arbitration.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_wr_add,
  output logic [DATA_W-1:0] ram_d_in,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_rd_add,
  input  logic [DATA_W-1:0] ram_d_out
);

  logic [1:0] w_wreq, w_rreq, w_wgnt, w_rgnt;
  logic       w_wr_pri_nxt, w_rd_pri_nxt;
  logic       r_wr_pri, r_rd_pri;
  logic       r_rvalid_p1, r_rd_own_p1;

  assign w_wreq = {m1_req &  m1_we, m0_req &  m0_we};
  assign w_rreq = {m1_req & ~m1_we, m0_req & ~m0_we};

  rr_arb2 u_wr_arb (
    .i_req      (w_wreq),
    .i_pri      (r_wr_pri),
    .i_update   (~rst),
    .o_gnt      (w_wgnt),
    .o_next_pri (w_wr_pri_nxt)
  );

  rr_arb2 u_rd_arb (
    .i_req      (w_rreq),
    .i_pri      (r_rd_pri),
    .i_update   (~rst),
    .o_gnt      (w_rgnt),
    .o_next_pri (w_rd_pri_nxt)
  );

  assign ram_write  = |w_wgnt;
  assign ram_wr_add = w_wgnt[M1] ? m1_addr  : m0_addr;
  assign ram_d_in   = w_wgnt[M1] ? m1_wdata : m0_wdata;
  assign ram_read   = |w_rgnt;
  assign ram_rd_add = w_rgnt[M1] ? m1_addr  : m0_addr;

  assign m0_gnt = w_wgnt[M0] | w_rgnt[M0];
  assign m1_gnt = w_wgnt[M1] | w_rgnt[M1];

  // p0 -> p1: read grant becomes rvalid for its owner when the RAM data lands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_pri    <= M0;
      r_rd_pri    <= M0;
      r_rvalid_p1 <= 1'b0;
      r_rd_own_p1 <= M0;
    end else begin
      r_wr_pri    <= w_wr_pri_nxt;
      r_rd_pri    <= w_rd_pri_nxt;
      r_rvalid_p1 <= |w_rgnt;
      r_rd_own_p1 <= w_rgnt[M1];
    end
  end

  // A read granted just before reset must not surface while reset is held.
  assign m0_rvalid = r_rvalid_p1 & (r_rd_own_p1 == M0) & ~rst;
  assign m1_rvalid = r_rvalid_p1 & (r_rd_own_p1 == M1) & ~rst;
  assign m0_rdata  = m0_rvalid ? ram_d_out : '0;
  assign m1_rdata  = m1_rvalid ? ram_d_out : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter with a RAM environment and a reference model.
module tb_ram_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_write, ram_read;
  logic [AW-1:0] ram_wr_add, ram_rd_add;
  logic [DW-1:0] ram_d_in, ram_d_out;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_write(ram_write), .ram_wr_add(ram_wr_add), .ram_d_in(ram_d_in),
    .ram_read(ram_read), .ram_rd_add(ram_rd_add), .ram_d_out(ram_d_out)
  );

  // Environment RAM: 16x8, registered read, read-before-write, cleared by reset.
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      ram_d_out <= '0;
    end else begin
      if (ram_read)  ram_d_out <= ram[ram_rd_add];
      if (ram_write) ram[ram_wr_add] <= ram_d_in;
    end
  end

  // Reference model state
  logic [DW-1:0] mmem [16];
  logic          mpri_w = 1'b0, mpri_r = 1'b0;
  logic          mpend_v = 1'b0, mpend_m = 1'b0;
  logic [DW-1:0] mpend_d = '0;
  logic          e_wv, e_wm, e_rv, e_rm;
  logic [37:0]   exp_v;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [37:0] obs();
    return {m0_gnt, m1_gnt,
            ram_write, (ram_write ? ram_wr_add : 4'h0), (ram_write ? ram_d_in : 8'h00),
            ram_read, (ram_read ? ram_rd_add : 4'h0),
            m0_rvalid, m0_rdata, m1_rvalid, m1_rdata};
  endfunction

  task automatic model_eval();
    logic wq0, wq1, rq0, rq1, g0, g1, v0, v1;
    logic [DW-1:0] d0, d1;
    wq0 = req[0] & we[0];  wq1 = req[1] & we[1];
    rq0 = req[0] & ~we[0]; rq1 = req[1] & ~we[1];
    e_wv = 1'b0; e_wm = 1'b0; e_rv = 1'b0; e_rm = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    if (!rst) begin
      e_wv = wq0 | wq1;
      e_wm = (wq0 && wq1) ? mpri_w : wq1;
      e_rv = rq0 | rq1;
      e_rm = (rq0 && rq1) ? mpri_r : rq1;
      if (mpend_v && !mpend_m) begin v0 = 1'b1; d0 = mpend_d; end
      if (mpend_v &&  mpend_m) begin v1 = 1'b1; d1 = mpend_d; end
    end
    g0 = (e_wv && !e_wm) || (e_rv && !e_rm);
    g1 = (e_wv &&  e_wm) || (e_rv &&  e_rm);
    exp_v = {g0, g1,
             e_wv, (e_wv ? addr[e_wm] : 4'h0), (e_wv ? wdata[e_wm] : 8'h00),
             e_rv, (e_rv ? addr[e_rm] : 4'h0),
             v0, d0, v1, d1};
  endtask

  task automatic model_commit();
    logic wq0, wq1, rq0, rq1;
    if (rst) begin
      mpri_w = 1'b0; mpri_r = 1'b0; mpend_v = 1'b0;
      for (int i = 0; i < 16; i++) mmem[i] = '0;
    end else begin
      wq0 = req[0] & we[0];  wq1 = req[1] & we[1];
      rq0 = req[0] & ~we[0]; rq1 = req[1] & ~we[1];
      mpend_v = e_rv;
      mpend_m = e_rm;
      if (e_rv) mpend_d = mmem[addr[e_rm]];
      if (e_wv) mmem[addr[e_wm]] = wdata[e_wm];
      if (wq0 && wq1) mpri_w = ~e_wm;
      if (rq0 && rq1) mpri_r = ~e_rm;
    end
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_m(input int m, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[m] = r; we[m] = w; addr[m] = a; wdata[m] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_m(0, 1'b1, 1'b1, 4'h1, 8'h55);
    set_m(1, 1'b1, 1'b0, 4'h2, 8'h00);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({m0_gnt, m1_gnt, ram_write, ram_read, m0_rvalid, m1_rvalid} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got=%b want=000000", i,
                 {m0_gnt, m1_gnt, ram_write, ram_read, m0_rvalid, m1_rvalid});
      end
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL reset_model got=%h want=%h", obs(), exp_v);
      end
      advance();
    end
    rst = 1'b0;
    set_m(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_m(1, 1'b0, 1'b0, 4'h0, 8'h00);
    settle(); advance();
  endtask

  task automatic test_parallel();
    set_m(0, 1'b1, 1'b1, 4'h3, 8'hA5);
    set_m(1, 1'b1, 1'b0, 4'h3, 8'h00);
    settle();
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b11) begin
      errors++; $display("FAIL parallel_gnt got=%b want=11", {m0_gnt, m1_gnt});
    end
    checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL parallel_model got=%h want=%h", obs(), exp_v); end
    advance();
    set_m(0, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    checks++;
    if (!(m1_rvalid === 1'b1 && m1_rdata === 8'h00)) begin
      errors++; $display("FAIL parallel_old_data got=%b/%h want=1/00", m1_rvalid, m1_rdata);
    end
    checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL parallel_model2 got=%h want=%h", obs(), exp_v); end
    advance();
    set_m(1, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    checks++;
    if (!(m1_rvalid === 1'b1 && m1_rdata === 8'hA5)) begin
      errors++; $display("FAIL parallel_new_data got=%b/%h want=1/a5", m1_rvalid, m1_rdata);
    end
    advance();
  endtask

  task automatic test_write_contention();
    set_m(0, 1'b1, 1'b1, 4'h5, 8'h11);
    set_m(1, 1'b1, 1'b1, 4'h5, 8'h22);
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL wr_alternate cyc%0d got=%b want=%b", i, {m0_gnt, m1_gnt},
                           ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL wr_model got=%h want=%h", obs(), exp_v); end
      advance();
    end
    set_m(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_m(1, 1'b0, 1'b0, 4'h0, 8'h00);
    settle(); advance();
  endtask

  task automatic test_read_contention();
    for (int i = 0; i < 7; i++) begin
      set_m(0, i < 6, 1'b0, 4'h5, 8'h00);
      set_m(1, i < 6, 1'b0, 4'h3, 8'h00);
      settle();
      checks++;
      if (m0_rvalid === 1'b1 && m1_rvalid === 1'b1) begin
        errors++; $display("FAIL rd_both_rvalid cyc%0d got=11 want=one-hot", i);
      end
      if (i >= 1) begin
        checks++;
        if ((i % 2 == 1) ? !(m0_rvalid === 1'b1 && m0_rdata === 8'h22)
                         : !(m1_rvalid === 1'b1 && m1_rdata === 8'hA5)) begin
          errors++; $display("FAIL rd_alternate cyc%0d got=%b%b/%h/%h", i,
                             m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
      end
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL rd_model got=%h want=%h", obs(), exp_v); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] fill [16];
    set_m(1, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      fill[i] = DW'($urandom);
      set_m(0, 1'b1, 1'b1, AW'(i), fill[i]);
      settle();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL fill_model got=%h want=%h", obs(), exp_v); end
      advance();
    end
    for (int i = 0; i < 17; i++) begin
      set_m(0, i < 16, 1'b0, AW'(i), 8'h00);
      settle();
      if (i >= 1) begin
        checks++;
        if (!(m0_rvalid === 1'b1 && m0_rdata === fill[i-1])) begin
          errors++; $display("FAIL pipe_read addr%0d got=%b/%h want=1/%h", i - 1,
                             m0_rvalid, m0_rdata, fill[i-1]);
        end
      end
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL pipe_model got=%h want=%h", obs(), exp_v); end
      advance();
    end
  endtask

  task automatic test_random();
    logic hold [2];
    logic granted;
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++)
        if (!hold[m])
          set_m(m, ($urandom % 4) != 0, $urandom % 2, AW'($urandom), DW'($urandom));
      settle();
      checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL rand_model cyc%0d got=%h want=%h", c, obs(), exp_v); end
      for (int m = 0; m < 2; m++) begin
        granted = we[m] ? (e_wv && e_wm == m[0]) : (e_rv && e_rm == m[0]);
        hold[m] = req[m] && !granted;
      end
      advance();
    end
    set_m(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_m(1, 1'b0, 1'b0, 4'h0, 8'h00);
    settle(); advance();
  endtask

  task automatic test_reset_mid_read();
    set_m(0, 1'b1, 1'b0, 4'h1, 8'h00);
    set_m(1, 1'b1, 1'b0, 4'h2, 8'h00);
    if (mpri_r) begin settle(); advance(); end
    settle();
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL mid_setup_gnt got=%b want=10", {m0_gnt, m1_gnt});
    end
    advance();
    set_m(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_m(1, 1'b1, 1'b0, 4'h7, 8'h00);
    settle();
    checks++;
    if (m1_gnt !== 1'b1) begin errors++; $display("FAIL mid_m1_gnt got=%b want=1", m1_gnt); end
    advance();
    rst = 1'b1;
    set_m(1, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 8'h00) begin
      errors++; $display("FAIL mid_rvalid_dropped got=%b/%h want=0/00", m1_rvalid, m1_rdata);
    end
    advance();
    rst = 1'b0;
    set_m(0, 1'b1, 1'b0, 4'h1, 8'h00);
    set_m(1, 1'b1, 1'b0, 4'h2, 8'h00);
    settle();
    checks++;
    if ({m0_gnt, m1_gnt, m1_rvalid} !== 3'b100) begin
      errors++; $display("FAIL mid_pri_reset got=%b want=100", {m0_gnt, m1_gnt, m1_rvalid});
    end
    checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL mid_model got=%h want=%h", obs(), exp_v); end
    advance();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    set_m(0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_m(1, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    test_reset();
    test_parallel();
    test_write_contention();
    test_read_contention();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
